// File: rtl/gemm_job_scheduler.sv
// gemm_job_scheduler: round-robin job scheduler in front of the 8x8 int8 GEMM core.
// Grants one of two requesters, pulses core start, waits for done (ignoring the
// stale done level for the first two RUN cycles), pulses core reset, then holds
// a response until it is consumed.
// Optional watchdog: define GEMM_SCHED_WATCHDOG_EN to abort jobs that run for
// TIMEOUT_CYCLES without done; the timeout response sets a sticky fault and
// parks the scheduler in FAULT until reset.
module gemm_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 2047,
  parameter int CNT_W          = 11
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  input  logic             req1_valid_i,
  output logic             req0_ready_o,
  output logic             req1_ready_o,
  output logic             core_start_o,
  output logic             core_reset_o,
  input  logic             core_done_i,
  input  logic [CNT_W-1:0] core_clock_count_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [CNT_W-1:0] rsp_cycles_o,
  output logic             rsp_timeout_o,
  output logic             busy_o,
  output logic             fault_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_RELEASE,
    S_RESP,
    S_FAULT
  } state_e;

  // Done is ignored while the guard counter climbs to this value.
  localparam logic [1:0] GUARD_LAST = 2'd2;

  state_e           state_q;
  logic             last_grant_q;
  logic             busy_q;
  logic             core_start_q;
  logic             core_reset_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] rsp_cycles_q;
  logic [1:0]       guard_q;
  logic             grant0_d;
  logic             grant1_d;

`ifdef GEMM_SCHED_WATCHDOG_EN
  localparam logic [CNT_W:0] WD_LAST = (CNT_W+1)'(TIMEOUT_CYCLES - 1);
  logic [CNT_W:0] wd_q;
  logic           rsp_timeout_q;
  logic           fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Round-robin grant decode: only in IDLE, the requester not granted last wins a tie.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid_i && (!req1_valid_i || last_grant_q)) begin
        grant0_d = 1'b1;
      end else if (req1_valid_i) begin
        grant1_d = 1'b1;
      end
    end
  end

  // Job sequencing FSM with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      busy_q        <= 1'b0;
      core_start_q  <= 1'b0;
      core_reset_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_cycles_q  <= '0;
      guard_q       <= '0;
`ifdef GEMM_SCHED_WATCHDOG_EN
      wd_q          <= '0;
      rsp_timeout_q <= 1'b0;
      fault_q       <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant0_d || grant1_d) begin
            rsp_id_q     <= grant1_d;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end
        S_START: begin
          guard_q <= '0;
`ifdef GEMM_SCHED_WATCHDOG_EN
          wd_q    <= '0;
`endif
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (guard_q != GUARD_LAST) begin
            guard_q <= guard_q + 2'd1;
          end
          if (guard_q == GUARD_LAST && core_done_i) begin
            rsp_cycles_q  <= core_clock_count_i;
            core_reset_q  <= 1'b1;
            state_q       <= S_RELEASE;
`ifdef GEMM_SCHED_WATCHDOG_EN
            rsp_timeout_q <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            // Core ignores reset while running, so skip RELEASE.
            rsp_cycles_q  <= '1;
            rsp_timeout_q <= 1'b1;
            fault_q       <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wd_q <= wd_q + (CNT_W+1)'(1);
`endif
          end
        end
        S_RELEASE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            last_grant_q <= rsp_id_q;
`ifdef GEMM_SCHED_WATCHDOG_EN
            if (rsp_timeout_q) begin
              state_q <= S_FAULT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_ready_o = grant0_d;
  assign req1_ready_o = grant1_d;
  assign core_start_o = core_start_q;
  assign core_reset_o = core_reset_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_cycles_o = rsp_cycles_q;
  assign busy_o       = busy_q;
`ifdef GEMM_SCHED_WATCHDOG_EN
  assign rsp_timeout_o = rsp_timeout_q;
  assign fault_o       = fault_q;
`else
  assign rsp_timeout_o = 1'b0;
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_job_scheduler.sv
// Directed testbench for gemm_job_scheduler.
module tb_gemm_job_scheduler;

  localparam int CNT_W = 11;
`ifdef GEMM_SCHED_WATCHDOG_EN
  localparam int TB_TIMEOUT = 50;
  localparam int SINGLE_DLY = 45;
`else
  localparam int TB_TIMEOUT = 2047;
  localparam int SINGLE_DLY = 77;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req0_ready;
  logic             req1_ready;
  logic             core_start;
  logic             core_reset;
  logic             core_done = 1'b0;
  logic [CNT_W-1:0] core_cnt = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_id;
  logic [CNT_W-1:0] rsp_cycles;
  logic             rsp_timeout;
  logic             busy;
  logic             fault;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_rst    = 0;

  gemm_job_scheduler #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .req0_valid_i      (req0_valid),
    .req1_valid_i      (req1_valid),
    .req0_ready_o      (req0_ready),
    .req1_ready_o      (req1_ready),
    .core_start_o      (core_start),
    .core_reset_o      (core_reset),
    .core_done_i       (core_done),
    .core_clock_count_i(core_cnt),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_id_o          (rsp_id),
    .rsp_cycles_o      (rsp_cycles),
    .rsp_timeout_o     (rsp_timeout),
    .busy_o            (busy),
    .fault_o           (fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_start) n_start++;
    if (core_reset) n_rst++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Core stand-in: waits for start, raises done after dly cycles, drops it on core reset.
  task automatic serve_job(input int dly, input logic [CNT_W-1:0] cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (core_start) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) return;
    repeat (dly) tick();
    core_done = 1'b1;
    core_cnt  = cnt;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (core_reset) begin ok = 1'b1; break; end
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++; if ({busy, core_start, core_reset, rsp_valid, rsp_id, rsp_cycles, rsp_timeout, fault} !== '0)
      $display("FAIL reset_outputs: got %b want all 0", {busy, core_start, core_reset, rsp_valid, rsp_id, rsp_cycles, rsp_timeout, fault}); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_job();
    int s0, r0;
    bit ok;
    s0 = n_start; r0 = n_rst;
    req0_valid = 1'b1;
    #1;
    n_checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); else n_pass++;
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({core_start, busy} !== 2'b11) $display("FAIL single_start: got %b want 11", {core_start, busy}); else n_pass++;
    serve_job(SINGLE_DLY, 11'd77, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL single_serve: got %b want 1", ok); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_early: got %b want 0", rsp_valid); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_timeout} !== 3'b100) $display("FAIL single_rsp: got %b want 100", {rsp_valid, rsp_id, rsp_timeout}); else n_pass++;
    n_checks++; if (rsp_cycles !== 11'd77) $display("FAIL single_cycles: got %0d want 77", rsp_cycles); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL single_idle: got %b want 00", {busy, rsp_valid}); else n_pass++;
    n_checks++; if (n_start - s0 !== 1) $display("FAIL single_start_cnt: got %0d want 1", n_start - s0); else n_pass++;
    n_checks++; if (n_rst - r0 !== 1) $display("FAIL single_reset_cnt: got %0d want 1", n_rst - r0); else n_pass++;
  endtask

  task automatic test_round_robin();
    int s0, polls;
    bit ok;
    logic exp_id;
    do_reset();
    s0 = n_start;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_id = (j % 2 == 1);
      polls = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (req0_ready || req1_ready) break;
        polls++;
        tick();
      end
      n_checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01))
        $display("FAIL rr_grant%0d: got %b want %b", j, {req1_ready, req0_ready}, (exp_id ? 2'b10 : 2'b01)); else n_pass++;
      if (j > 0) begin
        n_checks++; if (polls !== 0) $display("FAIL rr_b2b%0d: got %0d idle polls want 0", j, polls); else n_pass++;
      end
      tick();
      serve_job(3 + j, 11'(100 + j), ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL rr_serve%0d: got %b want 1", j, ok); else n_pass++;
      tick();
      n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, exp_id}) $display("FAIL rr_rsp%0d: got %b want %b", j, {rsp_valid, rsp_id}, {1'b1, exp_id}); else n_pass++;
      n_checks++; if (rsp_cycles !== 11'(100 + j)) $display("FAIL rr_cycles%0d: got %0d want %0d", j, rsp_cycles, 100 + j); else n_pass++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (j == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    repeat (2) tick();
    n_checks++; if (n_start - s0 !== 4) $display("FAIL rr_start_cnt: got %0d want 4", n_start - s0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_stale_done();
    bit early;
    do_reset();
    core_cnt  = 11'd5;
    core_done = 1'b1;
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    n_checks++; if (core_start !== 1'b1) $display("FAIL stale_start: got %b want 1", core_start); else n_pass++;
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (core_reset !== 1'b0) early = 1'b1;
      if (k == 3) core_done = 1'b0;
      if (k == 10) begin
        core_done = 1'b1;
        core_cnt  = 11'd10;
      end
    end
    n_checks++; if (early !== 1'b0) $display("FAIL stale_early_capture: got %b want 0", early); else n_pass++;
    tick();
    n_checks++; if (core_reset !== 1'b1) $display("FAIL stale_release: got %b want 1", core_reset); else n_pass++;
    core_done = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_cycles} !== {1'b1, 11'd10}) $display("FAIL stale_rsp: got %b/%0d want 1/10", rsp_valid, rsp_cycles); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int s0, bad;
    bit ok;
    do_reset();
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    serve_job(4, 11'd33, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL bp_serve: got %b want 1", ok); else n_pass++;
    tick();
    s0 = n_start;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_cycles !== 11'd33 || req1_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (n_start - s0 !== 0) $display("FAIL bp_no_start: got %0d want 0", n_start - s0); else n_pass++;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req1_ready !== 1'b0) $display("FAIL bp_ready_in_resp: got %b want 0", req1_ready); else n_pass++;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++; if ({busy, rsp_valid, req1_ready} !== 3'b001) $display("FAIL bp_regrant: got %b want 001", {busy, rsp_valid, req1_ready}); else n_pass++;
    tick();
    req1_valid = 1'b0;
    n_checks++; if (core_start !== 1'b1) $display("FAIL bp_start1: got %b want 1", core_start); else n_pass++;
    serve_job(3, 11'd44, ok);
    tick();
    n_checks++; if ({ok, rsp_valid, rsp_id, rsp_cycles} !== {3'b111, 11'd44}) $display("FAIL bp_rsp1: got %b want %b", {ok, rsp_valid, rsp_id, rsp_cycles}, {3'b111, 11'd44}); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int r0, bad;
    bit ok;
    do_reset();
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    r0 = n_rst;
    reset = 1'b1;
    #1;
    n_checks++; if ({busy, core_start, core_reset, rsp_valid, rsp_id, rsp_cycles, rsp_timeout, fault} !== '0)
      $display("FAIL mid_async_clear: got %b want all 0", {busy, core_start, core_reset, rsp_valid, rsp_id, rsp_cycles, rsp_timeout, fault}); else n_pass++;
    repeat (2) tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL mid_no_rsp: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++; if (n_rst - r0 !== 0) $display("FAIL mid_no_core_reset: got %0d want 0", n_rst - r0); else n_pass++;
    req0_valid = 1'b1;
    #1;
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL mid_regrant: got %b want 1", req0_ready); else n_pass++;
    tick();
    req0_valid = 1'b0;
    serve_job(6, 11'd66, ok);
    tick();
    n_checks++; if ({ok, rsp_valid, rsp_id, rsp_cycles} !== {3'b110, 11'd66}) $display("FAIL mid_rsp: got %b want %b", {ok, rsp_valid, rsp_id, rsp_cycles}, {3'b110, 11'd66}); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

`ifdef GEMM_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    int r0, waited, bad;
    bit got;
    do_reset();
    r0 = n_rst;
    req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    waited = 0;
    got = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (rsp_valid) begin got = 1'b1; break; end
      tick();
      waited++;
    end
    n_checks++; if (got !== 1'b1) $display("FAIL wd_rsp: got %b want 1", got); else n_pass++;
    n_checks++; if (waited < 50 || waited > 52) $display("FAIL wd_latency: got %0d want 50..52", waited); else n_pass++;
    n_checks++; if ({rsp_timeout, rsp_cycles, fault} !== {1'b1, 11'h7FF, 1'b1}) $display("FAIL wd_data: got %b want %b", {rsp_timeout, rsp_cycles, fault}, {1'b1, 11'h7FF, 1'b1}); else n_pass++;
    n_checks++; if (n_rst - r0 !== 0) $display("FAIL wd_no_core_reset: got %0d want 0", n_rst - r0); else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req0_ready || req1_ready || core_start || !busy || !fault) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL wd_fault_hold: got %0d bad cycles want 0", bad); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if ({fault, req1_ready, req0_ready} !== 3'b001) $display("FAIL wd_after_reset: got %b want 001", {fault, req1_ready, req0_ready}); else n_pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish within budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_stale_done();
    test_backpressure();
    test_reset_mid_job();
`ifdef GEMM_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
